// File: rtl/fadd_pkg.sv
// rtl/fadd_pkg.sv - shared floating-point add datapath widths and helpers
//
// Purpose: default mantissa/exponent widths for the FP add datapath and a
// behavioural leading-one index helper for use by other arithmetic blocks.
// Ports: none (package).

package fadd_pkg;

  localparam int MANT_W    = 10;
  localparam int EXP_W     = 5;
  localparam int LOD_MAX_W = 64;

  // Index of the highest set bit of vec; 0 when vec is all zeros.
  function automatic int lod_index(input logic [LOD_MAX_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < LOD_MAX_W; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/lod_find.sv
// rtl/lod_find.sv - combinational tree-structured leading-one finder
//
// Purpose: finds the index of the most-significant set bit of vec_i.
// Ports:
//   vec_i   in  WIDTH  vector to search
//   pos_o   out POS_W  index of the leading one (0 when vec_i is zero)
//   zero_o  out 1      vec_i is all zeros

module lod_find import fadd_pkg::*; #(
  parameter int  WIDTH = MANT_W,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [POS_W-1:0] pos_o,
  output logic             zero_o
);

  // Heap-ordered binary tree: node n has children 2n (lower bits) and 2n+1
  // (upper bits); leaves live at LEAVES+k for bit k. Each node carries the
  // absolute index of the leading one in its subtree, so the root is the answer.
  localparam int LEAVES = 1 << POS_W;

  logic             node_v [1:2*LEAVES-1];
  logic [POS_W-1:0] node_p [1:2*LEAVES-1];

  genvar k, n;
  for (k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < WIDTH) begin : g_real
      assign node_v[LEAVES+k] = vec_i[k];
    end else begin : g_pad
      assign node_v[LEAVES+k] = 1'b0;
    end
    assign node_p[LEAVES+k] = POS_W'(k);
  end

  // Upper half wins when it holds any one; an empty tree falls through to leaf 0.
  for (n = 1; n < LEAVES; n++) begin : g_node
    assign node_v[n] = node_v[2*n+1] | node_v[2*n];
    assign node_p[n] = node_v[2*n+1] ? node_p[2*n+1] : node_p[2*n];
  end

  assign zero_o = ~node_v[1];
  assign pos_o  = node_p[1];

endmodule

// File: rtl/lod_normalizer.sv
// rtl/lod_normalizer.sv - two-stage pipelined leading-one normaliser
//
// Purpose: locates the leading one of an unnormalised mantissa, shifts it to
// the MSB and lowers the exponent to match, clamping at exponent zero
// (denormal result). Valid/ready handshake on both sides, capacity 2 beats.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_mant, in_exp       unnormalised mantissa, biased exponent
//   out_valid/out_ready   output handshake
//   out_mant, out_exp     normalised mantissa, adjusted exponent
//   out_pos, out_shift    leading-one index, applied left shift
//   out_zero, out_denorm  input was zero, shift clamped by exponent

module lod_normalizer #(
  parameter int  WIDTH = fadd_pkg::MANT_W,
  parameter int  EXP_W = fadd_pkg::EXP_W,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [POS_W-1:0] out_pos,
  output logic [POS_W-1:0] out_shift,
  output logic             out_zero,
  output logic             out_denorm
);

  localparam int CMP_W = (EXP_W > POS_W) ? EXP_W : POS_W;

  logic [POS_W-1:0] lod_pos;
  logic             lod_zero;

  lod_find #(.WIDTH(WIDTH)) u_lod_find (
    .vec_i  (in_mant),
    .pos_o  (lod_pos),
    .zero_o (lod_zero)
  );

  // Stage 1 state
  logic             s1_v_q;
  logic [WIDTH-1:0] s1_mant_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [POS_W-1:0] s1_pos_q;
  logic             s1_zero_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_v_q;
  logic [WIDTH-1:0] s2_mant_q,   s2_mant_d;
  logic [EXP_W-1:0] s2_exp_q,    s2_exp_d;
  logic [POS_W-1:0] s2_pos_q;
  logic [POS_W-1:0] s2_shift_q,  s2_shift_d;
  logic             s2_zero_q;
  logic             s2_denorm_q, s2_denorm_d;

  logic             s1_adv, s2_adv;
  logic [POS_W-1:0] req;
  logic [CMP_W-1:0] req_ext, exp_ext;

  assign s2_adv   = ~s2_v_q | out_ready;
  assign s1_adv   = ~s1_v_q | s2_adv;
  assign in_ready = s1_adv;

  // Shift needed to bring the leading one to the MSB, limited by how far the
  // exponent can drop before reaching zero.
  always_comb begin
    req         = POS_W'(WIDTH - 1) - s1_pos_q;
    req_ext     = CMP_W'(req);
    exp_ext     = CMP_W'(s1_exp_q);
    s2_shift_d  = '0;
    s2_exp_d    = '0;
    s2_denorm_d = 1'b0;
    if (s1_zero_q) begin
      s2_shift_d = '0;
    end else if (req_ext >= exp_ext) begin
      // exp < WIDTH here, so it fits in the shift field.
      s2_shift_d  = POS_W'(exp_ext);
      s2_denorm_d = 1'b1;
    end else begin
      s2_shift_d = req;
      s2_exp_d   = s1_exp_q - EXP_W'(req_ext);
    end
    s2_mant_d = s1_mant_q << s2_shift_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_pos_q    <= '0;
      s1_zero_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_mant_q   <= '0;
      s2_exp_q    <= '0;
      s2_pos_q    <= '0;
      s2_shift_q  <= '0;
      s2_zero_q   <= 1'b0;
      s2_denorm_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_mant_q <= in_mant;
          s1_exp_q  <= in_exp;
          s1_pos_q  <= lod_pos;
          s1_zero_q <= lod_zero;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_mant_q   <= s2_mant_d;
          s2_exp_q    <= s2_exp_d;
          s2_pos_q    <= s1_pos_q;
          s2_shift_q  <= s2_shift_d;
          s2_zero_q   <= s1_zero_q;
          s2_denorm_q <= s2_denorm_d;
        end
      end
    end
  end

  assign out_valid  = s2_v_q;
  assign out_mant   = s2_mant_q;
  assign out_exp    = s2_exp_q;
  assign out_pos    = s2_pos_q;
  assign out_shift  = s2_shift_q;
  assign out_zero   = s2_zero_q;
  assign out_denorm = s2_denorm_q;

endmodule

// File: tb/tb_lod_normalizer.sv
// tb/tb_lod_normalizer.sv - self-checking bench for lod_normalizer

module tb_lod_normalizer;

  localparam int W = 10;
  localparam int E = 5;
  localparam int P = 4;

  typedef struct packed {
    logic [W-1:0] mant;
    logic [E-1:0] exp;
    logic [P-1:0] pos;
    logic [P-1:0] shift;
    logic         zero;
    logic         denorm;
  } res_t;

  typedef struct {
    logic [W-1:0] m;
    logic [E-1:0] e;
    res_t         r;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_mant = '0;
  logic [E-1:0] in_exp = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_mant;
  logic [E-1:0] out_exp;
  logic [P-1:0] out_pos;
  logic [P-1:0] out_shift;
  logic         out_zero;
  logic         out_denorm;

  int n_vec = 0;
  int n_err = 0;

  res_t exp_q[$];
  int   age_q[$];

  lod_normalizer #(.WIDTH(W), .EXP_W(E)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_pos    (out_pos),
    .out_shift  (out_shift),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  always #5 clk = ~clk;

  // Reference: scan for the top one, shift by min(room to MSB, exponent).
  function automatic res_t model(input logic [W-1:0] m, input logic [E-1:0] e);
    res_t r;
    int   p;
    int   req;
    int   sh;
    r = '0;
    p = -1;
    for (int i = 0; i < W; i++) if (m[i]) p = i;
    if (p < 0) begin
      r.zero = 1'b1;
      return r;
    end
    r.pos = P'(p);
    req   = W - 1 - p;
    if (req >= int'(e)) begin
      sh       = int'(e);
      r.denorm = 1'b1;
    end else begin
      sh = req;
    end
    r.shift = P'(sh);
    r.exp   = E'(int'(e) - sh);
    r.mant  = W'((int'(m) << sh) & ((1 << W) - 1));
    return r;
  endfunction

  function automatic res_t observed();
    return {out_mant, out_exp, out_pos, out_shift, out_zero, out_denorm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    age_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_mant = 10'h155;
    in_exp = 5'd7;
    out_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_vec++;
    if (observed() !== res_t'(0)) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", observed());
    end
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t dv[7];
    dv[0] = '{m: 10'b1000000100, e: 5'd16, r: {10'b1000000100, 5'd16, 4'd9, 4'd0, 1'b0, 1'b0}};
    dv[1] = '{m: 10'b0000000100, e: 5'd16, r: {10'b1000000000, 5'd9, 4'd2, 4'd7, 1'b0, 1'b0}};
    dv[2] = '{m: 10'b0000000100, e: 5'd3,  r: {10'b0000100000, 5'd0, 4'd2, 4'd3, 1'b0, 1'b1}};
    dv[3] = '{m: 10'b0000000000, e: 5'd20, r: {10'b0000000000, 5'd0, 4'd0, 4'd0, 1'b1, 1'b0}};
    dv[4] = '{m: 10'b0000010000, e: 5'd0,  r: {10'b0000010000, 5'd0, 4'd4, 4'd0, 1'b0, 1'b1}};
    dv[5] = '{m: 10'b0000000001, e: 5'd9,  r: {10'b1000000000, 5'd0, 4'd0, 4'd9, 1'b0, 1'b1}};
    dv[6] = '{m: 10'b0000000001, e: 5'd10, r: {10'b1000000000, 5'd1, 4'd0, 4'd9, 1'b0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_mant = dv[i].m;
      in_exp = dv[i].e;
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_latency1[%0d]: got out_valid %b expected 0", i, out_valid);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL directed_latency2[%0d]: got out_valid %b expected 1", i, out_valid);
      end
      n_vec++;
      if (observed() !== dv[i].r) begin
        n_err++;
        $display("FAIL directed_data[%0d]: got %h expected %h", i, observed(), dv[i].r);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bm[4];
    logic [E-1:0] be[4];
    int sent;
    int got;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bm[i] = W'($urandom) | 10'h001;
      be[i] = E'($urandom);
    end
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid = (sent < 4);
      if (sent < 4) begin
        in_mant = bm[sent];
        in_exp = be[sent];
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_full_in_ready cyc%0d: got %b expected 0", cyc, in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b1 || observed() !== model(bm[0], be[0])) begin
          n_err++;
          $display("FAIL b2b_hold_A cyc%0d: got v=%b %h expected v=1 %h", cyc, out_valid, observed(), model(bm[0], be[0]));
        end
      end
      if (cyc >= 4 && cyc <= 7) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_no_gap cyc%0d: got out_valid %b expected 1", cyc, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (got >= 4 || observed() !== model(bm[got & 3], be[got & 3])) begin
          n_err++;
          $display("FAIL b2b_order beat%0d: got %h expected %h", got, observed(), model(bm[got & 3], be[got & 3]));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    n_vec++;
    if (got !== 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d beats expected 4", got);
    end
  endtask

  task automatic test_random();
    logic held_v;
    res_t held;
    logic exp_ov;
    logic exp_ir;
    do_reset();
    held_v = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid = (cyc < 590) && ($urandom_range(0, 3) != 0);
      in_mant = W'($urandom) >> $urandom_range(0, W);
      in_exp = E'($urandom);
      out_ready = (cyc >= 590) || ($urandom_range(0, 3) != 0);
      #1;
      exp_ov = (exp_q.size() > 0) && (age_q[0] >= 2);
      exp_ir = !(exp_q.size() == 2 && !out_ready);
      n_vec++;
      if (out_valid !== exp_ov) begin
        n_err++;
        $display("FAIL rand_out_valid cyc%0d: got %b expected %b", cyc, out_valid, exp_ov);
      end
      n_vec++;
      if (in_ready !== exp_ir) begin
        n_err++;
        $display("FAIL rand_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_ir);
      end
      if (held_v) begin
        n_vec++;
        if (observed() !== held) begin
          n_err++;
          $display("FAIL rand_stall_hold cyc%0d: got %h expected %h", cyc, observed(), held);
        end
      end
      held_v = out_valid && !out_ready;
      held = observed();
      if (out_valid && out_ready && exp_q.size() > 0) begin
        n_vec++;
        if (observed() !== exp_q[0]) begin
          n_err++;
          $display("FAIL rand_data cyc%0d: got %h expected %h", cyc, observed(), exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_mant, in_exp));
        age_q.push_back(0);
      end
      tick();
      foreach (age_q[i]) age_q[i]++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d undelivered beats expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_mant = 10'h080 >> i;
      in_exp = 5'd12;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_stale cyc%0d: got out_valid %b expected 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lod_normalizer.md
Name: lod_normalizer

Overview:
- Parametrised, pipelined leading-one detector and normaliser for the floating-point add datapath.
- Takes an unnormalised mantissa and biased exponent and finds the most-significant set bit. It then left-shifts the mantissa so that bit is at the MSB and decrements the exponent to match.
- Clamps at exponent zero to produce denormals.
- Two-stage pipeline with valid/ready handshake; sits between the mantissa adder and the rounding stage.

Parameters:
- WIDTH, 10, mantissa width in bits (>= 2).
- EXP_W, 5, biased exponent width.
- POS_W, $clog2(WIDTH), derived localparam; width of position and shift fields.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept the input beat.
- in_mant  in  WIDTH  unnormalised mantissa.
- in_exp  in  EXP_W  biased exponent.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_mant  out  WIDTH  normalised mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_pos  out  POS_W  index of the leading one in in_mant (MSB = WIDTH-1).
- out_shift  out  POS_W  left shift actually applied.
- out_zero  out  1  in_mant was all zeros.
- out_denorm  out  1  shift was clamped by the exponent; result is denormal.

Behaviour:
- Reset: one clock, synchronous, active-high, as fixed above. While reset is high at a clock edge, both stage valids clear and out_valid = 0. Data registers are cleared too: out_mant = 0, out_exp = 0, out_pos = 0, out_shift = 0, out_zero = 0, out_denorm = 0.
- Reset mid-operation: in-flight beats are discarded, not delivered. in_ready = 1 in the first cycle after reset deasserts.
- Stage 1 (s1), registered: mant, exp, pos, zero.
  - pos = index of the highest set bit of in_mant.
  - zero = ~|in_mant; when zero, pos = 0.
- Stage 2 (s2), registered outputs:
  - req = WIDTH-1-pos.
  - If zero: shift = 0, out_mant = 0, out_exp = 0, out_denorm = 0.
  - Else if req >= in_exp (compare after zero-extending to max(EXP_W, POS_W)): shift = in_exp, out_exp = 0, out_denorm = 1.
  - Else: shift = req, out_exp = in_exp - req, out_denorm = 0.
  - out_mant = mant << shift, with zero fill.
- Handshake:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
  - in_ready = s1_adv, combinational from out_ready and state only, never from in_valid.
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 beat per cycle.
- Stall: while out_valid & ~out_ready, all out_* fields hold stable. s1 keeps filling, so capacity is 2 beats; in_ready drops only when both stages are full and out_ready = 0.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Simultaneous output transfer and full pipeline: s2 takes s1 and s1 takes the input in the same edge.
- in_mant MSB already set: shift = 0, data and exponent pass through unchanged.
- in_exp = 0 with nonzero mant: shift = 0, out_denorm = 1.

Decomposition:
- Shared package fadd_pkg holds:
  - constants MANT_W = 10 and EXP_W = 5, the default widths;
  - a function lod_index(vector) returning the MSB index, usable by other adders/multipliers.
- One sub-module, lod_find, is the natural split. It is a combinational, WIDTH-parametrised, tree-structured leading-one finder with outputs pos and zero. It replaces the fixed 2/4-bit encoder chain.
- Pipeline registers and handshake stay in lod_normalizer.

Test Plan (all with WIDTH=10, EXP_W=5):
- in_mant=10'b1000000100, in_exp=16, out_ready=1 -> after 2 cycles: out_pos=9, out_shift=0, out_mant=10'b1000000100, out_exp=16, out_denorm=0.
- in_mant=10'b0000000100, in_exp=16 -> out_pos=2, out_shift=7, out_mant=10'b1000000000, out_exp=9.
- in_mant=10'b0000000100, in_exp=3 -> out_shift=3, out_mant=10'b0000100000, out_exp=0, out_denorm=1.
- in_mant=0, in_exp=20 -> out_zero=1, out_mant=0, out_exp=0, out_shift=0.
- Back-to-back beats A,B,C,D with out_ready=0 for 4 cycles:
  - A and B are accepted, then in_ready=0 and out_* holds A.
  - After out_ready=1, outputs appear in order A,B,C,D, one per cycle, with no gaps.
- reset pulsed 1 cycle while 2 beats are in flight -> out_valid=0 next cycle, in_ready=1, no stale beat is delivered afterwards.
